// File: rtl/universal_shift_register.sv
// Universal shift register: single-step ops on en, multi-cycle bursts via start/busy/done.
// Define USR_PARITY_EN to add a registered even-parity output tracking q.
module universal_shift_register #(
   parameter  int bit_size = 8,
   localparam int SW       = $clog2(bit_size) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                start,
   input  logic [2:0]          mode,
   input  logic [SW-1:0]       shamt,
   input  logic                sin_r,
   input  logic                sin_l,
   input  logic [bit_size-1:0] d,
   output logic [bit_size-1:0] q,
   output logic                sout,
   output logic                busy,
`ifdef USR_PARITY_EN
   output logic                parity,
`endif
   output logic                done
);

   localparam int W = bit_size;

   typedef enum logic {IDLE, BURST} state_t;

   state_t        state_reg, state_next;
   logic [SW-1:0] count_reg, count_next;
   logic [2:0]    mode_r_reg, mode_r_next;
   logic [W-1:0]  q_reg, q_next;
   logic          sout_reg, sout_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          do_op;
   logic [2:0]    op;
   logic          mode_is_shift;

   assign mode_is_shift = (mode != 3'b000) && (mode < 3'b110);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         count_reg  <= '0;
         mode_r_reg <= 3'b000;
         q_reg      <= '0;
         sout_reg   <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         count_reg  <= count_next;
         mode_r_reg <= mode_r_next;
         q_reg      <= q_next;
         sout_reg   <= sout_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      count_next  = count_reg;
      mode_r_next = mode_r_reg;
      done_next   = 1'b0;
      do_op       = 1'b0;
      op          = mode;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (mode_is_shift && shamt != '0) begin
                  state_next  = BURST;
                  count_next  = shamt;
                  mode_r_next = mode;
               end else begin
                  // A shift mode only lands here with shamt=0, which is a no-op.
                  do_op     = !mode_is_shift;
                  done_next = 1'b1;
               end
            end else if (en) begin
               do_op = 1'b1;
            end
         end
         BURST: begin
            op         = mode_r_reg;
            do_op      = 1'b1;
            count_next = count_reg - SW'(1);
            if (count_reg == SW'(1)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == BURST);

      q_next    = q_reg;
      sout_next = sout_reg;
      if (do_op) begin
         case (op)
            3'b001: begin q_next = {q_reg[W-2:0], sin_r};       sout_next = q_reg[W-1]; end
            3'b010: begin q_next = {sin_l, q_reg[W-1:1]};       sout_next = q_reg[0];   end
            3'b011: begin q_next = {q_reg[W-2:0], q_reg[W-1]};  sout_next = q_reg[W-1]; end
            3'b100: begin q_next = {q_reg[0], q_reg[W-1:1]};    sout_next = q_reg[0];   end
            3'b101: begin q_next = {q_reg[W-1], q_reg[W-1:1]};  sout_next = q_reg[0];   end
            3'b110: q_next = d;
            3'b111: q_next = '0;
            default: q_next = q_reg;
         endcase
      end
   end

`ifdef USR_PARITY_EN
   logic parity_reg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) parity_reg <= 1'b0;
      else     parity_reg <= ^q_next;
   end
   assign parity = parity_reg;
`endif

   assign q    = q_reg;
   assign sout = sout_reg;
   assign busy = busy_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_universal_shift_register.sv
// Randomised self-checking bench for universal_shift_register against an arithmetic model.
// Define USR_PARITY_EN for both files to exercise the parity output.
module tb_universal_shift_register;
   localparam int W  = 8;
   localparam int SW = $clog2(W) + 1;

   logic          clk = 1'b0;
   logic          rst, en, start, sin_r, sin_l;
   logic [2:0]    mode;
   logic [SW-1:0] shamt;
   logic [W-1:0]  d, q;
   logic          sout, busy, done;
`ifdef USR_PARITY_EN
   logic          parity;
`endif

   int checks = 0;
   int errors = 0;

   // model state
   logic [W-1:0] m_q;
   logic         m_sout, m_busy, m_done;
   int           m_cnt;
   logic [2:0]   m_mode;

   universal_shift_register #(.bit_size(W)) dut (
      .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .shamt(shamt),
      .sin_r(sin_r), .sin_l(sin_l), .d(d), .q(q), .sout(sout), .busy(busy),
`ifdef USR_PARITY_EN
      .parity(parity),
`endif
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_op(input logic [2:0] m);
      case (m)
         3'd1: begin m_sout = m_q[W-1]; m_q = (m_q << 1) | W'(sin_r); end
         3'd2: begin m_sout = m_q[0];   m_q = (m_q >> 1) | (W'(sin_l) << (W-1)); end
         3'd3: begin m_sout = m_q[W-1]; m_q = (m_q << 1) | (m_q >> (W-1)); end
         3'd4: begin m_sout = m_q[0];   m_q = (m_q >> 1) | (m_q << (W-1)); end
         3'd5: begin m_sout = m_q[0];   m_q = W'($signed(m_q) >>> 1); end
         3'd6: m_q = d;
         3'd7: m_q = '0;
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_q = '0; m_sout = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;
   endtask

   // Advance one clock with the current inputs and compare every output.
   task automatic step();
      logic nd;
      nd = 0;
      if (rst) model_reset();
      else if (!m_busy) begin
         if (start) begin
            if (mode >= 3'd1 && mode <= 3'd5 && shamt != 0) begin
               m_busy = 1; m_cnt = int'(shamt); m_mode = mode;
            end else begin
               if (!(mode >= 3'd1 && mode <= 3'd5)) model_op(mode);
               nd = 1;
            end
         end else if (en) model_op(mode);
      end else begin
         model_op(m_mode);
         m_cnt--;
         if (m_cnt == 0) begin m_busy = 0; nd = 1; end
      end
      m_done = nd;
      @(posedge clk);
      #1;
      $display("cycle rst=%0b en=%0b start=%0b mode=%0d shamt=%0d q=%h sout=%0b busy=%0b done=%0b",
               rst, en, start, mode, shamt, q, sout, busy, done);
      check("q", q, m_q);
      check("sout", sout, m_sout);
      check("busy", busy, m_busy);
      check("done", done, m_done);
`ifdef USR_PARITY_EN
      check("parity", parity, ^m_q);
`endif
   endtask

   task automatic cyc(input logic e, input logic s, input logic [2:0] m, input int sh,
                      input logic sr, input logic sl, input logic [W-1:0] dd);
      en = e; start = s; mode = m; shamt = SW'(sh); sin_r = sr; sin_l = sl; d = dd;
      step();
   endtask

   initial begin
      rst = 1; en = 0; start = 0; mode = 0; shamt = 0; sin_r = 0; sin_l = 0; d = 0;
      model_reset();
      #1;
      check("rst_q", q, 0);
      check("rst_busy", busy, 0);
      step();
      rst = 0;

      // single step
      cyc(1, 0, 3'd6, 0, 0, 0, 8'hA5);  check("ld_q", q, 8'hA5);
      cyc(1, 0, 3'd1, 0, 1, 0, 8'h00);  check("shl_q", q, 8'h4B); check("shl_sout", sout, 1);
      cyc(0, 0, 3'd1, 0, 1, 0, 8'h00);  check("hold_q", q, 8'h4B);

      // ROL burst
      cyc(1, 0, 3'd6, 0, 0, 0, 8'h81);
      cyc(0, 1, 3'd3, 3, 0, 0, 8'h00);  check("rol_acc_q", q, 8'h81);
      cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);  check("rol_q1", q, 8'h03); check("rol_s1", sout, 1);
      cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);  check("rol_q2", q, 8'h06); check("rol_s2", sout, 0);
      cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);  check("rol_q3", q, 8'h0C); check("rol_done", done, 1);

      // ASR burst with disturbing inputs
      cyc(1, 0, 3'd6, 0, 0, 0, 8'h80);
      cyc(0, 1, 3'd5, 8, 0, 0, 8'h00);
      for (int i = 0; i < 8; i++) begin
         check("asr_busy", busy, 1);
         cyc(1, 1, 3'($urandom), int'($urandom_range(0, 15)), 0, 0, 8'($urandom));
      end
      check("asr_q", q, 8'hFF); check("asr_sout", sout, 1); check("asr_done", done, 1);

      // degenerate starts
      cyc(0, 1, 3'd1, 0, 1, 1, 8'h00);  check("deg_q", q, 8'hFF); check("deg_done", done, 1);
      cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);  check("deg_done_end", done, 0);
      cyc(0, 1, 3'd7, 4, 0, 0, 8'h00);  check("clr_q", q, 8'h00); check("clr_busy", busy, 0);

      // max-count rotate and saturating SHR
      cyc(1, 0, 3'd6, 0, 0, 0, 8'h35);
      cyc(0, 1, 3'd4, 15, 0, 0, 8'h00);
      repeat (15) cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);
      check("ror15_q", q, 8'h6A);
      cyc(0, 1, 3'd2, 12, 0, 1, 8'h00);
      repeat (12) cyc(0, 0, 3'd0, 0, 0, 1, 8'h00);
      check("shr12_q", q, 8'hFF);

`ifdef USR_PARITY_EN
      cyc(1, 0, 3'd6, 0, 0, 0, 8'h07);  check("par_07", parity, 1);
      cyc(1, 0, 3'd1, 0, 0, 0, 8'h00);  check("par_0e_q", q, 8'h0E); check("par_0e", parity, 1);
      cyc(1, 0, 3'd6, 0, 0, 0, 8'h03);  check("par_03", parity, 0);
`endif

      // async reset mid-burst
      cyc(1, 0, 3'd6, 0, 0, 0, 8'hF0);
      cyc(0, 1, 3'd4, 5, 0, 0, 8'h00);
      cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);
      cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);
      #2 rst = 1;
      #1;
      check("arst_q", q, 0); check("arst_busy", busy, 0); check("arst_sout", sout, 0);
      model_reset();
      step();
      rst = 0;
      repeat (5) begin
         cyc(0, 0, 3'd0, 0, 0, 0, 8'h00);
         check("arst_nodone", done, 0);
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 1), ($urandom_range(0, 5) == 0), 3'($urandom),
             ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)),
             1'($urandom), 1'($urandom), 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised universal shift register with mode select: hold, logical shift left/right, rotate left/right, arithmetic shift right, parallel load and clear. It has two operating styles. Single-step operations run one cycle per enable. Multi-cycle burst shifts use a start/busy/done handshake and a programmable shift count. It serves as the general serialiser/deserialiser and barrel-shift-by-cycles element for datapath blocks.

Parameters:
- bit_size, 8, register width in bits; must be >= 2.
- Derived, not overridable: SW = $clog2(bit_size)+1, the shamt width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  single-step enable; honoured only in IDLE with start=0.
- start  input  1  burst request; honoured only in IDLE.
- mode  input  3  operation select; see Behaviour.
- shamt  input  SW  burst shift count; sampled on start.
- sin_r  input  1  serial bit entering bit 0 on SHL.
- sin_l  input  1  serial bit entering bit bit_size-1 on SHR.
- d  input  bit_size  parallel load data.
- q  output  bit_size  register contents.
- sout  output  1  registered; last bit shifted or rotated out.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse on operation completion.
- parity  output  1  only when USR_PARITY_EN is defined.

Behaviour:
- Reset: q=0, sout=0, busy=0, done=0, parity=0, state=IDLE, count=0. Reset takes effect immediately and asynchronously. It aborts any burst; no done pulse follows.
- Modes (W = bit_size):
  - 000 HOLD.
  - 001 SHL: q<={q[W-2:0],sin_r}, sout<=q[W-1].
  - 010 SHR: q<={sin_l,q[W-1:1]}, sout<=q[0].
  - 011 ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
  - 100 ROR: q<={q[0],q[W-1:1]}, sout<=q[0].
  - 101 ASR: q<={q[W-1],q[W-1:1]}, sout<=q[0].
  - 110 LOAD: q<=d.
  - 111 CLEAR: q<=0.
- sout changes only in modes 001-101; otherwise it holds.
- States: IDLE, BURST.
- IDLE, start=1, mode in 001-101, shamt!=0:
  - Latch mode into mode_r and shamt into count; go to BURST; busy=1 from the next cycle.
  - No q change on the accept edge.
- IDLE, start=1, mode in 000/110/111, or shamt=0:
  - Perform the mode op once on that edge; with shamt=0, shift modes leave q unchanged.
  - Stay in IDLE; done=1 for the next cycle only; busy stays 0.
- IDLE, start=0, en=1: perform the mode op once; no done pulse.
- IDLE, start=0, en=0: hold.
- BURST, each cycle:
  - Execute mode_r; decrement count.
  - On the edge where count goes 1->0: state=IDLE, busy=0, done=1 for one cycle.
  - busy is high for exactly shamt cycles; q changes on each of those cycles' closing edges.
- In BURST, start, en, mode, shamt and d are ignored. sin_l/sin_r are sampled live every burst cycle.
- shamt up to 2^SW-1 is legal and is executed literally. Rotates wrap; shifts saturate to the fill pattern (all sin for SHL/SHR, all sign for ASR).
- start is accepted again in the cycle done is high; back-to-back bursts have one IDLE accept cycle between them.

Optional Feature:
- USR_PARITY_EN defined:
  - Adds output parity, registered, updated on the same edge as q, equal to ^(next q).
  - Reset value 0.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Async reset: ROR burst with shamt=5 on q=8'hF0; assert rst after 2 busy cycles -> q=0, busy=0, sout=0 immediately; done never pulses.
- Single step: en=1 mode=110 d=8'hA5 -> q=8'hA5; then en=1 mode=001 sin_r=1 -> q=8'h4B, sout=1; en=0 -> q holds.
- ROL burst: q=8'h81, start mode=011 shamt=3 -> busy high 3 cycles; q 8'h03, 8'h06, 8'h0C; sout 1, 0, 0; done one cycle as busy falls.
- ASR burst: q=8'h80, start mode=101 shamt=8 -> busy 8 cycles, final q=8'hFF, sout=1. Toggle mode/d/start during busy -> no effect.
- Degenerate start: start mode=001 shamt=0 -> q unchanged, busy stays 0, done pulses once. start mode=111 -> q=0, done pulses once.
- USR_PARITY_EN: load 8'h07 -> parity=1; SHL with sin_r=0 -> q=8'h0E, parity=1; load 8'h03 -> parity=0.
